// File: rtl/fft_stage_sequencer_if.sv
// Handshake and datapath bundle for fft_stage_sequencer.
// slave is the sequencer's view; master is the surrounding system
// (frame source/sink, MAC array, twiddle ROM).
interface fft_stage_sequencer_if #(
    parameter int unsigned DW    = 16,
    parameter int unsigned NPAIR = 16
);
    logic                    InValid;
    logic                    InReady;
    logic [2*NPAIR*DW-1:0]   InData;
    logic [2*NPAIR*DW-1:0]   MacIn1_2;
    logic [NPAIR*DW-1:0]     MacIn3;
    logic [2*NPAIR*DW-1:0]   MacOut1_2;
    logic                    MacOverflow;
    logic [2:0]              TwStage;
    logic [NPAIR*DW-1:0]     TwData;
    logic                    OutValid;
    logic                    OutReady;
    logic [2*NPAIR*DW-1:0]   OutData;
    logic                    Overflow;
    logic                    Busy;

    modport slave (
        input  InValid, InData, MacOut1_2, MacOverflow, TwData, OutReady,
        output InReady, MacIn1_2, MacIn3, TwStage, OutValid, OutData, Overflow, Busy
    );

    modport master (
        output InValid, InData, MacOut1_2, MacOverflow, TwData, OutReady,
        input  InReady, MacIn1_2, MacIn3, TwStage, OutValid, OutData, Overflow, Busy
    );
endinterface

// File: rtl/fft_stage_sequencer.sv
// Iterative stage controller for a radix-2 DIF FFT built around an external
// butterfly MAC array. One stage per cycle, results written back in place.
// Optional macro FFT_BITREV_EN: present OutData in natural frequency order.
module fft_stage_sequencer #(
    parameter int unsigned DW     = 16,
    parameter int unsigned NPAIR  = 16,
    parameter int unsigned NSTAGE = 5
) (
    input logic                   Clk,
    input logic                   Rst,
    fft_stage_sequencer_if.slave  bus
);
    localparam int unsigned NSAMP = 2 * NPAIR;
    localparam int unsigned IW    = $clog2(NSAMP);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t        state_q, state_d;
    logic [2:0]    stage_q, stage_d;
    logic          ovf_q, ovf_d;
    logic [DW-1:0] buf_q [NSAMP];
    logic [DW-1:0] buf_d [NSAMP];
    logic [IW-1:0] lo_idx [NPAIR];
    logic [IW-1:0] hi_idx [NPAIR];

    // Lower sample index of butterfly p in stage s (stride NPAIR>>s).
    function automatic logic [IW-1:0] pair_lo(input int unsigned p, input logic [2:0] s);
        int unsigned k;
        int unsigned stride;
        k      = NSTAGE - 1 - 32'(s);
        stride = NPAIR >> s;
        return IW'(((p >> k) << (k + 1)) | (p & (stride - 1)));
    endfunction

    function automatic logic [IW-1:0] bitrev(input logic [IW-1:0] v);
        logic [IW-1:0] r;
        for (int b = 0; b < int'(IW); b++) r[b] = v[IW-1-b];
        return r;
    endfunction

    // Butterfly addressing for the current stage.
    always_comb begin
        for (int unsigned p = 0; p < NPAIR; p++) begin
            lo_idx[p] = pair_lo(p, stage_q);
            hi_idx[p] = lo_idx[p] + IW'(NPAIR >> stage_q);
        end
    end

    // Next-state, buffer write-back and handshake outputs.
    always_comb begin
        state_d      = state_q;
        stage_d      = stage_q;
        ovf_d        = ovf_q;
        buf_d        = buf_q;
        bus.InReady  = 1'b0;
        bus.OutValid = 1'b0;
        bus.Busy     = 1'b0;
        bus.TwStage  = '0;
        bus.MacIn1_2 = '0;
        bus.MacIn3   = '0;
        unique case (state_q)
            StIdle: begin
                bus.InReady = 1'b1;
                if (bus.InValid) begin
                    for (int unsigned i = 0; i < NSAMP; i++) buf_d[i] = bus.InData[DW*i +: DW];
                    ovf_d   = 1'b0;
                    stage_d = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                bus.Busy    = 1'b1;
                bus.TwStage = stage_q;
                bus.MacIn3  = bus.TwData;
                for (int unsigned p = 0; p < NPAIR; p++) begin
                    bus.MacIn1_2[2*DW*p +: DW]      = buf_q[lo_idx[p]];
                    bus.MacIn1_2[2*DW*p + DW +: DW] = buf_q[hi_idx[p]];
                    buf_d[lo_idx[p]] = bus.MacOut1_2[2*DW*p +: DW];
                    buf_d[hi_idx[p]] = bus.MacOut1_2[2*DW*p + DW +: DW];
                end
                ovf_d = ovf_q | bus.MacOverflow;
                if (stage_q == 3'(NSTAGE - 1)) begin
                    stage_d = '0;
                    state_d = StDone;
                end else begin
                    stage_d = stage_q + 3'd1;
                end
            end
            StDone: begin
                bus.Busy     = 1'b1;
                bus.OutValid = 1'b1;
                if (bus.OutReady) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Reset is synchronous, so outputs are forced low while it is held.
        if (Rst) begin
            bus.InReady  = 1'b0;
            bus.OutValid = 1'b0;
            bus.Busy     = 1'b0;
            bus.TwStage  = '0;
            bus.MacIn1_2 = '0;
            bus.MacIn3   = '0;
        end
    end

    assign bus.Overflow = ovf_q & ~Rst;

    // Output ordering: raw DIF (bit-reversed) or permuted to natural order.
    for (genvar i = 0; i < int'(NSAMP); i++) begin : g_out
`ifdef FFT_BITREV_EN
        localparam logic [IW-1:0] SRC = bitrev(IW'(i));
        assign bus.OutData[DW*i +: DW] = buf_q[SRC];
`else
        assign bus.OutData[DW*i +: DW] = buf_q[i];
`endif
    end

    // Control state; reset discards any partial frame.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= StIdle;
            stage_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            ovf_q   <= ovf_d;
        end
    end

    // Frame buffer; contents after reset are don't-care.
    always_ff @(posedge Clk) begin
        buf_q <= buf_d;
    end
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer with a behavioural MAC array stub
// (pass-through or sum/difference) and a stage-tagged twiddle ROM.
module tb_fft_stage_sequencer;
    localparam int DW    = 16;
    localparam int NPAIR = 16;
    localparam int NSAMP = 32;

    logic Clk;
    logic Rst;
    logic mac_sum;
    logic ovf_stage2;
    logic ovf_force;
    int   n_checks;
    int   n_errors;

    fft_stage_sequencer_if #(.DW(DW), .NPAIR(NPAIR)) bus ();

    fft_stage_sequencer #(.DW(DW), .NPAIR(NPAIR), .NSTAGE(5)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // MAC array stub: Add/Sub either pass operands through or form sum/difference.
    always_comb begin
        bus.MacOut1_2 = '0;
        for (int p = 0; p < NPAIR; p++) begin
            if (mac_sum) begin
                bus.MacOut1_2[32*p +: 16]      = bus.MacIn1_2[32*p +: 16] + bus.MacIn1_2[32*p+16 +: 16];
                bus.MacOut1_2[32*p + 16 +: 16] = bus.MacIn1_2[32*p +: 16] - bus.MacIn1_2[32*p+16 +: 16];
            end else begin
                bus.MacOut1_2[32*p +: 16]      = bus.MacIn1_2[32*p +: 16];
                bus.MacOut1_2[32*p + 16 +: 16] = bus.MacIn1_2[32*p+16 +: 16];
            end
        end
    end

    // Twiddle ROM stub: lane p of stage s reads back as s*2048 + p.
    always_comb begin
        bus.TwData = '0;
        for (int p = 0; p < NPAIR; p++) bus.TwData[16*p +: 16] = 16'(32'(bus.TwStage) * 2048 + p);
    end

    assign bus.MacOverflow = ovf_force | (ovf_stage2 & (bus.TwStage == 3'd2));

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [15:0] out_slot(input int i);
        return bus.OutData[16*i +: 16];
    endfunction

    function automatic logic [15:0] op1(input int p);
        return bus.MacIn1_2[32*p +: 16];
    endfunction

    function automatic logic [15:0] op2(input int p);
        return bus.MacIn1_2[32*p + 16 +: 16];
    endfunction

    // Present a frame for one cycle; it is accepted on this edge.
    task automatic send_frame(input logic [511:0] data);
        bus.InData  = data;
        bus.InValid = 1'b1;
        check_value("accept_ready", 32'(bus.InReady), 32'd1);
        tick();
        bus.InValid = 1'b0;
    endtask

    // Edges counted after the accept edge until OutValid is seen, bounded.
    task automatic wait_valid(output int edges);
        edges = 0;
        while (!bus.OutValid && edges < 20) begin
            tick();
            edges++;
        end
        if (!bus.OutValid) check_value("valid_timeout", 32'(bus.OutValid), 32'd1);
    endtask

    task automatic drain();
        bus.OutReady = 1'b1;
        tick();
        bus.OutReady = 1'b0;
    endtask

    logic [511:0] frame;
    logic [511:0] snap;
    int           edges;
    logic         seen;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        Rst          = 1'b1;
        mac_sum      = 1'b0;
        ovf_stage2   = 1'b0;
        ovf_force    = 1'b0;
        bus.InValid  = 1'b0;
        bus.InData   = '0;
        bus.OutReady = 1'b0;
        tick();
        tick();
        check_value("rst_inready", 32'(bus.InReady), 32'd0);
        check_value("rst_outvalid", 32'(bus.OutValid), 32'd0);
        check_value("rst_busy", 32'(bus.Busy), 32'd0);
        check_value("rst_overflow", 32'(bus.Overflow), 32'd0);
        Rst = 1'b0;
        #1;
        check_value("idle_inready", 32'(bus.InReady), 32'd1);

        // Pairing: x[i] = i through a pass-through array keeps the buffer unchanged.
        for (int i = 0; i < NSAMP; i++) frame[16*i +: 16] = 16'(i);
        send_frame(frame);
        for (int s = 0; s < 5; s++) begin
            check_value($sformatf("twstage_s%0d", s), 32'(bus.TwStage), 32'(s));
            check_value($sformatf("tw_lane0_s%0d", s), 32'(bus.MacIn3[15:0]), 32'(s * 2048));
            check_value($sformatf("tw_lane15_s%0d", s), 32'(bus.MacIn3[255:240]), 32'(s * 2048 + 15));
            check_value($sformatf("busy_s%0d", s), 32'(bus.Busy), 32'd1);
            check_value($sformatf("outvalid_s%0d", s), 32'(bus.OutValid), 32'd0);
            if (s == 0) begin
                check_value("s0_p0", {op1(0), op2(0)}, {16'd0, 16'd16});
                check_value("s0_p15", {op1(15), op2(15)}, {16'd15, 16'd31});
            end
            if (s == 1) check_value("s1_p1", {op1(1), op2(1)}, {16'd1, 16'd9});
            if (s == 4) begin
                check_value("s4_p0", {op1(0), op2(0)}, {16'd0, 16'd1});
                check_value("s4_p15", {op1(15), op2(15)}, {16'd30, 16'd31});
            end
            tick();
        end
        // Accept at edge T, last write at T+5: OutValid is visible right after T+5.
        check_value("pass_outvalid", 32'(bus.OutValid), 32'd1);
`ifdef FFT_BITREV_EN
        check_value("brev_slot0", 32'(out_slot(0)), 32'd0);
        check_value("brev_slot1", 32'(out_slot(1)), 32'd16);
        check_value("brev_slot2", 32'(out_slot(2)), 32'd8);
        check_value("brev_slot3", 32'(out_slot(3)), 32'd24);
        check_value("brev_slot31", 32'(out_slot(31)), 32'd31);
`else
        for (int i = 0; i < NSAMP; i++)
            check_value($sformatf("raw_slot%0d", i), 32'(out_slot(i)), 32'(i));
`endif
        drain();
        check_value("ret_idle_outvalid", 32'(bus.OutValid), 32'd0);
        check_value("ret_idle_inready", 32'(bus.InReady), 32'd1);

        // Impulse through the sum stub spreads evenly to every output.
        mac_sum = 1'b1;
        frame   = '0;
        frame[15:0] = 16'h0100;
        send_frame(frame);
        wait_valid(edges);
        check_value("impulse_latency", 32'(edges), 32'd5);
        for (int i = 0; i < NSAMP; i++)
            check_value($sformatf("impulse_slot%0d", i), 32'(out_slot(i)), 32'h0100);
        check_value("impulse_overflow", 32'(bus.Overflow), 32'd0);
        drain();

        // All-ones input collapses into DC; overflow raised in stage 2 only.
        for (int i = 0; i < NSAMP; i++) frame[16*i +: 16] = 16'h0001;
        ovf_stage2 = 1'b1;
        send_frame(frame);
        wait_valid(edges);
        check_value("ones_latency", 32'(edges), 32'd5);
        check_value("ones_slot0", 32'(out_slot(0)), 32'h0020);
        seen = 1'b0;
        for (int i = 1; i < NSAMP; i++) if (out_slot(i) != 16'h0) seen = 1'b1;
        check_value("ones_others_zero", 32'(seen), 32'd0);
        check_value("ovf_with_valid", 32'(bus.Overflow), 32'd1);
        ovf_stage2 = 1'b0;

        // Backpressure: output held, frames offered upstream are refused.
        snap = bus.OutData;
        for (int c = 0; c < 10; c++) begin
            bus.InValid = c[0];
            tick();
            check_value($sformatf("bp_valid%0d", c), 32'(bus.OutValid), 32'd1);
            check_value($sformatf("bp_inready%0d", c), 32'(bus.InReady), 32'd0);
            check_value($sformatf("bp_slot0_%0d", c), 32'(out_slot(0)), 32'h0020);
            check_value($sformatf("bp_stable%0d", c), 32'(bus.OutData == snap), 32'd1);
            check_value($sformatf("bp_ovf%0d", c), 32'(bus.Overflow), 32'd1);
        end
        bus.InValid = 1'b0;
        drain();
        check_value("bp_idle_outvalid", 32'(bus.OutValid), 32'd0);
        check_value("bp_idle_inready", 32'(bus.InReady), 32'd1);
        check_value("bp_idle_busy", 32'(bus.Busy), 32'd0);

        // MacOverflow pulsed in IDLE; next accept must clear the sticky flag.
        ovf_force = 1'b1;
        tick();
        ovf_force = 1'b0;
        frame = '0;
        frame[15:0] = 16'h0100;
        send_frame(frame);
        check_value("ovf_clear_on_accept", 32'(bus.Overflow), 32'd0);
        wait_valid(edges);
        check_value("ovf_clean_frame", 32'(bus.Overflow), 32'd0);
        ovf_force = 1'b1;
        tick();
        check_value("ovf_ignored_done", 32'(bus.Overflow), 32'd0);
        ovf_force = 1'b0;
        drain();

        // Reset during stage 2 discards the frame.
        mac_sum    = 1'b0;
        ovf_stage2 = 1'b1;
        send_frame(frame);
        edges = 0;
        while (bus.TwStage != 3'd2 && edges < 10) begin
            tick();
            edges++;
        end
        check_value("reach_stage2", 32'(bus.TwStage), 32'd2);
        Rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            check_value($sformatf("mid_rst_inready%0d", c), 32'(bus.InReady), 32'd0);
            check_value($sformatf("mid_rst_outvalid%0d", c), 32'(bus.OutValid), 32'd0);
            check_value($sformatf("mid_rst_busy%0d", c), 32'(bus.Busy), 32'd0);
            check_value($sformatf("mid_rst_ovf%0d", c), 32'(bus.Overflow), 32'd0);
            tick();
        end
        Rst        = 1'b0;
        ovf_stage2 = 1'b0;
        #1;
        check_value("post_rst_inready", 32'(bus.InReady), 32'd1);
        check_value("post_rst_busy", 32'(bus.Busy), 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.OutValid || bus.Busy) seen = 1'b1;
        end
        check_value("post_rst_no_frame", 32'(seen), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
